// File: rtl/embed_load_ctrl.sv
// Linear-embedding load sequencer: streams bias and weight bytes from the parameter ROM into the
// embedding register file, then launches the dot-product engine under a watchdog.
module embed_load_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BS_BASE    = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] WT_BASE    = 8'h10,
    parameter int unsigned           DEPTH      = 16,
    parameter int unsigned           TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     skip_load_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic                     params_valid_o,
    output logic                     rom_en_o,
    output logic [ADDR_WIDTH-1:0]    rom_addr_o,
    input  logic [DATA_WIDTH-1:0]    rom_data_i,
    output logic                     bs_we_o,
    output logic                     wt_we_o,
    output logic [$clog2(DEPTH)-1:0] wr_idx_o,
    output logic [DATA_WIDTH-1:0]    wr_data_o,
    output logic                     dp_start_o,
    input  logic                     dp_done_i
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned WdW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);
    localparam logic [WdW-1:0]  WdLimit = WdW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLoadBs,
        StLoadWt,
        StFlush,
        StCompute,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            entry_q, entry_d;
    logic            pv_q, pv_d;
    logic            err_q, err_d;
    logic            wr_vld_q, wr_vld_d;
    logic            wr_sel_q, wr_sel_d;
    logic [IdxW-1:0] wr_idx_q, wr_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wd_q     <= '0;
            entry_q  <= 1'b0;
            pv_q     <= 1'b0;
            err_q    <= 1'b0;
            wr_vld_q <= 1'b0;
            wr_sel_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            entry_q  <= entry_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
            wr_vld_q <= wr_vld_d;
            wr_sel_q <= wr_sel_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wd_d     = '0;
        pv_d     = pv_q;
        err_d    = err_q;
        // Write stage replays each read one cycle later, when the ROM data arrives.
        wr_vld_d = (state_q == StLoadBs) || (state_q == StLoadWt);
        wr_sel_d = (state_q == StLoadWt);
        wr_idx_d = idx_q;

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start_i) begin
                    err_d = 1'b0;
                    if (skip_load_i && pv_q) begin
                        state_d = StCompute;
                    end else begin
                        state_d = StLoadBs;
                        pv_d    = 1'b0;
                    end
                end
            end
            StLoadBs: begin
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StLoadWt;
                end
            end
            StLoadWt: begin
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                pv_d    = 1'b1;
                state_d = StCompute;
            end
            StCompute: begin
                wd_d = wd_q + WdW'(1);
                // The entry cycle may still see a stale level from a previous run.
                if (!entry_q && dp_done_i) begin
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (wd_q == WdLimit)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        entry_d = (state_d == StCompute) && (state_q != StCompute);
    end

    always_comb begin
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StDone);
        error_o        = err_q;
        params_valid_o = pv_q;
        rom_en_o       = 1'b0;
        rom_addr_o     = '0;
        if (state_q == StLoadBs) begin
            rom_en_o   = 1'b1;
            rom_addr_o = BS_BASE + ADDR_WIDTH'(idx_q);
        end else if (state_q == StLoadWt) begin
            rom_en_o   = 1'b1;
            rom_addr_o = WT_BASE + ADDR_WIDTH'(idx_q);
        end
        bs_we_o    = wr_vld_q && !wr_sel_q;
        wt_we_o    = wr_vld_q && wr_sel_q;
        wr_idx_o   = wr_idx_q;
        wr_data_o  = wr_vld_q ? rom_data_i : '0;
        dp_start_o = (state_q == StCompute) && entry_q;
    end

endmodule

// File: doc/embed_load_ctrl.md
# embed_load_ctrl

Sequencer for the linear-embedding stage. On `start` it fetches the 16 bias bytes and 16 weight bytes from the synchronous parameter ROM (Q4.4, one byte per address) and writes them into the embedding register file through write strobes. It then launches the dot-product engine and waits for its completion, with a watchdog. It sits between the top-level layer scheduler (start/done) and the ROM, parameter registers and dot-product datapath.

## Interface
- `ADDR_WIDTH`, 8: ROM address width.
- `DATA_WIDTH`, 8: ROM/parameter word width (Q4.4).
- `BS_BASE`, 8'h00: ROM address of bias[0].
- `WT_BASE`, 8'h10: ROM address of embed_wt[0].
- `DEPTH`, 16: entries per table (bias and weight each); ≥ 2.
- `TIMEOUT`, 1024: max cycles waiting for `dp_done`; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `skip_load`  in  1  sampled with `start`; reuse loaded parameters if `params_valid`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky watchdog flag.
- `params_valid`  out  1  both tables fully loaded since reset.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  `ADDR_WIDTH`  ROM read address.
- `rom_data`  in  `DATA_WIDTH`  ROM data; valid 1 cycle after `rom_en`.
- `bs_we`  out  1  bias register write strobe.
- `wt_we`  out  1  weight register write strobe.
- `wr_idx`  out  `$clog2(DEPTH)`  register index for the current write.
- `wr_data`  out  `DATA_WIDTH`  write data; combinational passthrough of `rom_data`.
- `dp_start`  out  1  one-cycle launch pulse to the dot-product engine.
- `dp_done`  in  1  dot-product completion (level or pulse).

## Operation
- **States:** IDLE, LOAD_BS, LOAD_WT, FLUSH, COMPUTE, DONE.
- **IDLE:**
  - `start`=1 with `skip_load`=1 and `params_valid`=1 → COMPUTE.
  - `start`=1 otherwise → LOAD_BS and `params_valid` is cleared.
  - Accepting `start` clears `error`.
- **LOAD_BS:**
  - Read-index counter `idx` runs 0..DEPTH-1, one read per cycle.
  - `rom_en`=1, `rom_addr`=`BS_BASE`+`idx`.
  - At `idx`=DEPTH-1 → LOAD_WT and `idx` resets to 0.
- **LOAD_WT:** same as LOAD_BS with `WT_BASE`. At `idx`=DEPTH-1 → FLUSH.
- **Write stage:** one-cycle delayed copy of (read valid, table select, `idx`).
  - Next cycle after each read: `bs_we` or `wt_we`=1, `wr_idx`=delayed `idx`, `wr_data`=`rom_data`.
  - `bs_we` and `wt_we` are never high together.
- **FLUSH:**
  - `rom_en`=0; carries the final weight write.
  - Sets `params_valid`=1; → COMPUTE.
- **COMPUTE:**
  - `dp_start`=1 on the entry cycle only.
  - `dp_done` is ignored on the entry cycle; sampled from the following cycle.
  - `dp_done`=1 → DONE.
  - Watchdog counter clears on entry. With `TIMEOUT`≠0, reaching `TIMEOUT` cycles without `dp_done` sets `error`=1 → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Ignored inputs:** `start` while `busy`; `dp_done` outside COMPUTE.
- **Reset (any time, including mid-load):**
  - State → IDLE; counters and write-stage pipeline cleared.
  - Every output = 0, including `params_valid` and `error`.
  - No write strobe may fire after reset is released.

## Timing
- Cycle 0: IDLE, `start`=1 sampled (full load).
- Cycles 1..16: LOAD_BS, `rom_addr` = `BS_BASE`+0..15.
- Cycles 2..17: `bs_we`, `wr_idx` 0..15.
- Cycles 17..32: LOAD_WT, `rom_addr` = `WT_BASE`+0..15.
- Cycles 18..33: `wt_we`, `wr_idx` 0..15.
- Cycle 33: FLUSH (last weight write); `params_valid` rises at cycle 34.
- Cycle 34: COMPUTE entry, `dp_start`=1.
- `dp_done` sampled high at cycle N (N ≥ 35): DONE at N+1 (`done`=1), IDLE at N+2.
- Full-load overhead: 34 cycles + engine time + 2.
- `skip_load` path: start at cycle 0 → COMPUTE/`dp_start` at 1. Sampling `dp_done` at N (N ≥ 2) gives `done` at N+1.
- Watchdog: `TIMEOUT`=T with no `dp_done` → `error` and `done` at entry + T + 1.

## Test plan
- **Full load:** ROM[a]=a^8'h5A, `start` pulse, `dp_done` at cycle 40.
  - 16 `bs_we` with `wr_data`=(`BS_BASE`+i)^8'h5A.
  - 16 `wt_we` likewise with `WT_BASE`.
  - `dp_start` only at cycle 34; `done` at 41; `busy` cycles 1..41.
- **Skip path:** after the full load, `start`+`skip_load`.
  - No `rom_en` and no write strobes.
  - `dp_start` at cycle 1; `done` one cycle after `dp_done`.
- **Skip denied:** `skip_load`=1 right after reset → full 32-read load occurs.
- **Watchdog:** `TIMEOUT`=8, `dp_done` tied 0.
  - `error`=1 and `done` 9 cycles after `dp_start`.
  - Next accepted `start` clears `error`.
- **Mid-load reset:** `rst` asserted at cycle 10.
  - All outputs 0 immediately; `params_valid`=0.
  - No strobes after release.
  - A restart loads all 32 entries.
- **Protocol abuse:**
  - `start` held high throughout → exactly one sequence per IDLE visit.
  - `dp_done` held high during load → ignored until COMPUTE entry+1.
